// File: rtl/comblock_axi4_burst_ram_if.sv
// AXI4 burst bus bundle for comblock_axi4_burst_ram (32-bit data, INCR-only).
interface comblock_axi4_burst_ram_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
);
  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic              AWVALID;
  logic              AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );
endinterface

// File: rtl/comblock_axi4_burst_ram.sv
// AXI4 INCR burst slave over a word-addressed dual-port RAM.
// Independent write (IDLE/DATA/RESP) and read (IDLE/FETCH/DATA) FSMs.
// Optional macro COMBLOCK_RAM_ADDR_CHECK_EN: beats past the top of the RAM
// are flagged SLVERR instead of wrapping (writes dropped, reads return 0).
module comblock_axi4_burst_ram #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input logic ACLK,
  input logic ARESET,
  comblock_axi4_burst_ram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef COMBLOCK_RAM_ADDR_CHECK_EN
  // Extra bits keep the unwrapped index so overruns can be detected.
  localparam int IW = AW + 9;
`else
  localparam int IW = AW;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  logic [31:0] mem [DEPTH];

  logic              alive_q;
  wstate_t           wst_q, wst_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic              werr_q, werr_d;
  logic              wr_en, w_oor;

  rstate_t           rst_q, rst_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [IW-1:0]     ridx_q, ridx_d;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic              rerr_q;
  logic [31:0]       rdata_q;
  logic              rd_fetch, r_oor;

  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic              unused_addr_bits;

  assign aw_addr = bus.AWADDR;
  assign ar_addr = bus.ARADDR;
  assign unused_addr_bits = &{1'b0, aw_addr, ar_addr};

`ifdef COMBLOCK_RAM_ADDR_CHECK_EN
  assign w_oor = (widx_q >= IW'(DEPTH));
  assign r_oor = (ridx_q >= IW'(DEPTH));
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  // Holds both ready signals low until the first edge after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  // Write channel state and burst context registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wst_q  <= W_IDLE;
      wid_q  <= '0;
      widx_q <= '0;
      wlen_q <= '0;
      wcnt_q <= '0;
      werr_q <= 1'b0;
    end else begin
      wst_q  <= wst_d;
      wid_q  <= wid_d;
      widx_q <= widx_d;
      wlen_q <= wlen_d;
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
    end
  end

  // Write FSM: address accept, beat consumption with WLAST/length check, response.
  always_comb begin
    wst_d       = wst_q;
    wid_d       = wid_q;
    widx_d      = widx_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    werr_d      = werr_q;
    wr_en       = 1'b0;
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    case (wst_q)
      W_IDLE: begin
        bus.AWREADY = alive_q;
        if (alive_q && bus.AWVALID) begin
          wid_d  = bus.AWID;
          widx_d = IW'(aw_addr[2 +: AW]);
          wlen_d = bus.AWLEN;
          wcnt_d = '0;
          werr_d = 1'b0;
          wst_d  = W_DATA;
        end
      end
      W_DATA: begin
        bus.WREADY = 1'b1;
        if (bus.WVALID) begin
          wr_en  = !w_oor;
          widx_d = widx_q + IW'(1);
          wcnt_d = wcnt_q + 8'd1;
          if ((bus.WLAST != (wcnt_q == wlen_q)) || w_oor) werr_d = 1'b1;
          if (bus.WLAST || (wcnt_q == wlen_q)) wst_d = W_RESP;
        end
      end
      W_RESP: begin
        bus.BVALID = 1'b1;
        if (bus.BREADY) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  assign bus.BID   = wid_q;
  assign bus.BRESP = ((wst_q == W_RESP) && werr_q) ? 2'b10 : 2'b00;

  // RAM write port with per-byte enables.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.WSTRB[b]) mem[widx_q[AW-1:0]][8*b +: 8] <= bus.WDATA[8*b +: 8];
      end
    end
  end

  // Read channel state and burst context registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rst_q  <= R_IDLE;
      rid_q  <= '0;
      ridx_q <= '0;
      rlen_q <= '0;
      rcnt_q <= '0;
    end else begin
      rst_q  <= rst_d;
      rid_q  <= rid_d;
      ridx_q <= ridx_d;
      rlen_q <= rlen_d;
      rcnt_q <= rcnt_d;
    end
  end

  // RAM read port; registered data is held through R_DATA so a stall keeps RDATA stable.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else if (rd_fetch) begin
      rdata_q <= r_oor ? 32'd0 : mem[ridx_q[AW-1:0]];
      rerr_q  <= r_oor;
    end
  end

  // Read FSM: address accept, one RAM fetch per beat, present beat until RREADY.
  always_comb begin
    rst_d       = rst_q;
    rid_d       = rid_q;
    ridx_d      = ridx_q;
    rlen_d      = rlen_q;
    rcnt_d      = rcnt_q;
    rd_fetch    = 1'b0;
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b0;
    case (rst_q)
      R_IDLE: begin
        bus.ARREADY = alive_q;
        if (alive_q && bus.ARVALID) begin
          rid_d  = bus.ARID;
          ridx_d = IW'(ar_addr[2 +: AW]);
          rlen_d = bus.ARLEN;
          rcnt_d = '0;
          rst_d  = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_fetch = 1'b1;
        rst_d    = R_DATA;
      end
      R_DATA: begin
        bus.RVALID = 1'b1;
        if (bus.RREADY) begin
          if (rcnt_q == rlen_q) begin
            rst_d = R_IDLE;
          end else begin
            ridx_d = ridx_q + IW'(1);
            rcnt_d = rcnt_q + 8'd1;
            rst_d  = R_FETCH;
          end
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  assign bus.RID   = rid_q;
  assign bus.RDATA = rdata_q;
  assign bus.RRESP = ((rst_q == R_DATA) && rerr_q) ? 2'b10 : 2'b00;
  assign bus.RLAST = (rst_q == R_DATA) && (rcnt_q == rlen_q);
endmodule

// File: tb/tb_comblock_axi4_burst_ram.sv
// Directed bench for comblock_axi4_burst_ram; honours COMBLOCK_RAM_ADDR_CHECK_EN.
module tb_comblock_axi4_burst_ram;
`ifdef COMBLOCK_RAM_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comblock_axi4_burst_ram_if #(.ID_W(4), .ADDR_W(32)) bus ();

  comblock_axi4_burst_ram #(.ID_W(4), .ADDR_W(32), .DEPTH(256)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWVALID = 1'b1;
    n = 0;
    while (!bus.AWREADY && n < 30) begin @(negedge clk); n++; end
    chk("awready", {31'd0, bus.AWREADY}, 32'd1);
    @(negedge clk);
    bus.AWVALID = 1'b0;
  endtask

  task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic last);
    int n;
    bus.WDATA = d; bus.WSTRB = s; bus.WLAST = last; bus.WVALID = 1'b1;
    n = 0;
    while (!bus.WREADY && n < 30) begin @(negedge clk); n++; end
    chk("wready", {31'd0, bus.WREADY}, 32'd1);
    @(negedge clk);
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  task automatic bresp(input logic [3:0] id, input logic [1:0] resp);
    int n;
    bus.BREADY = 1'b1;
    n = 0;
    while (!bus.BVALID && n < 30) begin @(negedge clk); n++; end
    chk("bvalid", {31'd0, bus.BVALID}, 32'd1);
    chk("bid", {28'd0, bus.BID}, {28'd0, id});
    chk("bresp", {30'd0, bus.BRESP}, {30'd0, resp});
    @(negedge clk);
    bus.BREADY = 1'b0;
  endtask

  task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 30) begin @(negedge clk); n++; end
    chk("arready", {31'd0, bus.ARREADY}, 32'd1);
    @(negedge clk);
    bus.ARVALID = 1'b0;
  endtask

  task automatic wait_rvalid();
    int n;
    n = 0;
    while (!bus.RVALID && n < 30) begin @(negedge clk); n++; end
    chk("rvalid", {31'd0, bus.RVALID}, 32'd1);
  endtask

  task automatic rd_beat(input logic [31:0] d, input logic last, input logic [1:0] resp,
                         input logic [3:0] id);
    bus.RREADY = 1'b1;
    wait_rvalid();
    chk("rdata", bus.RDATA, d);
    chk("rlast", {31'd0, bus.RLAST}, {31'd0, last});
    chk("rresp", {30'd0, bus.RRESP}, {30'd0, resp});
    chk("rid", {28'd0, bus.RID}, {28'd0, id});
    @(negedge clk);
    bus.RREADY = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
    aw(4'd0, addr, 8'd0);
    wbeat(d, s, 1'b1);
    bresp(4'd0, 2'b00);
  endtask

  task automatic read_word(input logic [31:0] addr, input logic [31:0] d);
    ar(4'd0, addr, 8'd0);
    rd_beat(d, 1'b1, 2'b00, 4'd0);
  endtask

  initial begin
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    chk("rst_arready", {31'd0, bus.ARREADY}, 32'd0);
    chk("rst_wready",  {31'd0, bus.WREADY},  32'd0);
    chk("rst_bvalid",  {31'd0, bus.BVALID},  32'd0);
    chk("rst_rvalid",  {31'd0, bus.RVALID},  32'd0);
    chk("rst_rdata",   bus.RDATA,            32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_awready", {31'd0, bus.AWREADY}, 32'd1);
    chk("rel_arready", {31'd0, bus.ARREADY}, 32'd1);

    // 8-beat write then read back
    aw(4'd3, 32'h0, 8'd7);
    for (int i = 0; i < 8; i++) wbeat(32'(i + 1), 4'hF, i == 7);
    bresp(4'd3, 2'b00);
    ar(4'd5, 32'h0, 8'd7);
    for (int i = 0; i < 8; i++) rd_beat(32'(i + 1), i == 7, 2'b00, 4'd5);

    // First-beat latency and a 5-cycle stall on beat 3
    ar(4'd6, 32'h0, 8'd7);
    chk("lat_fetch", {31'd0, bus.RVALID}, 32'd0);
    @(negedge clk);
    chk("lat_data", {31'd0, bus.RVALID}, 32'd1);
    rd_beat(32'd1, 1'b0, 2'b00, 4'd6);
    rd_beat(32'd2, 1'b0, 2'b00, 4'd6);
    wait_rvalid();
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid", {31'd0, bus.RVALID}, 32'd1);
      chk("stall_rdata", bus.RDATA, 32'd3);
      @(negedge clk);
    end
    for (int i = 2; i < 8; i++) rd_beat(32'(i + 1), i == 7, 2'b00, 4'd6);

    // Reset during beat 4 of a read, then a fresh read
    ar(4'd7, 32'h0, 8'd7);
    for (int i = 0; i < 3; i++) rd_beat(32'(i + 1), 1'b0, 2'b00, 4'd7);
    wait_rvalid();
    chk("pre_rst_rdata", bus.RDATA, 32'd4);
    rst = 1'b1;
    #1;
    chk("inrst_rvalid", {31'd0, bus.RVALID}, 32'd0);
    chk("inrst_arready", {31'd0, bus.ARREADY}, 32'd0);
    @(negedge clk);
    chk("inrst_rvalid2", {31'd0, bus.RVALID}, 32'd0);
    chk("inrst_arready2", {31'd0, bus.ARREADY}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", {31'd0, bus.ARREADY}, 32'd1);
    chk("post_rst_rvalid", {31'd0, bus.RVALID}, 32'd0);
    ar(4'd8, 32'h8, 8'd1);
    rd_beat(32'd3, 1'b0, 2'b00, 4'd8);
    rd_beat(32'd4, 1'b1, 2'b00, 4'd8);

    // Byte strobes
    write_word(32'h40, 32'h11223344, 4'hF);
    write_word(32'h40, 32'hAABBCCDD, 4'h3);
    read_word(32'h40, 32'h1122CCDD);

    // Early WLAST, then a clean burst
    aw(4'd9, 32'h80, 8'd3);
    wbeat(32'h100, 4'hF, 1'b0);
    wbeat(32'h101, 4'hF, 1'b1);
    chk("early_wready", {31'd0, bus.WREADY}, 32'd0);
    bresp(4'd9, 2'b10);
    aw(4'd4, 32'h80, 8'd3);
    for (int i = 0; i < 4; i++) wbeat(32'h200 + 32'(i), 4'hF, i == 3);
    bresp(4'd4, 2'b00);
    read_word(32'h8C, 32'h203);

    // Length reached without WLAST
    aw(4'd10, 32'hA0, 8'd1);
    wbeat(32'h1, 4'hF, 1'b0);
    wbeat(32'h2, 4'hF, 1'b0);
    chk("nolast_wready", {31'd0, bus.WREADY}, 32'd0);
    bresp(4'd10, 2'b10);

    // Burst crossing the top of the RAM
    write_word(32'h0, 32'h55, 4'hF);
    aw(4'd1, 32'h3FC, 8'd1);
    wbeat(32'hA, 4'hF, 1'b0);
    wbeat(32'hB, 4'hF, 1'b1);
    bresp(4'd1, CHK_EN ? 2'b10 : 2'b00);
    read_word(32'h3FC, 32'hA);
    read_word(32'h0, CHK_EN ? 32'h55 : 32'hB);
    ar(4'd2, 32'h3FC, 8'd1);
    rd_beat(32'hA, 1'b0, 2'b00, 4'd2);
    rd_beat(CHK_EN ? 32'h0 : 32'hB, 1'b1, CHK_EN ? 2'b10 : 2'b00, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
